// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder and its MMIO register block.
// Optional CYCLE_CNT register is controlled by macro DATA_MEM_CYCLE_CNT_EN.
package data_mem_responder_pkg;

  localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;

  localparam logic [7:0] OFF_STATUS    = 8'h00;
  localparam logic [7:0] OFF_STORE_CNT = 8'h04;
  localparam logic [7:0] OFF_SCRATCH   = 8'h08;
  localparam logic [7:0] OFF_CYCLE_CNT = 8'h0C;

  localparam int ST_MISALIGN = 0;
  localparam int ST_OOR      = 1;
  localparam int ST_WR_CLEAR = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic is_mmio_page(input logic [23:0] page);
    return page == MMIO_BASE;
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped status/counter registers of the data-memory responder.
// Define DATA_MEM_CYCLE_CNT_EN to build the free-running CYCLE_CNT register at 0x0C.
module dmem_mmio_regs
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  status_set,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [31:0] wr_data,
  input  logic        store_inc,
  output logic [31:0] rd_data,
  output logic [2:0]  status
);

  logic [31:0] store_cnt;
  logic [31:0] scratch;
  logic [2:0]  clr_mask;

  always_comb begin
    clr_mask = 3'b000;
    if (wr_en && offset == OFF_STATUS) clr_mask = wr_data[2:0];
  end

  // W1C clear is applied first so a same-cycle set event survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= 3'b000;
      store_cnt <= 32'd0;
      scratch   <= 32'd0;
    end else begin
      status <= (status & ~clr_mask) | status_set;
      if (store_inc) store_cnt <= store_cnt + 32'd1;
      if (wr_en && offset == OFF_SCRATCH) scratch <= wr_data;
    end
  end

`ifdef DATA_MEM_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
    end else if (wr_en && offset == OFF_CYCLE_CNT) begin
      cycle_cnt <= 32'd0;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  logic unused_run;
  assign unused_run = run;
`endif

  // Misaligned offsets match no case item and therefore read as zero
  always_comb begin
    rd_data = 32'd0;
    case (offset)
      OFF_STATUS:    rd_data = {29'd0, status};
      OFF_STORE_CNT: rd_data = store_cnt;
      OFF_SCRATCH:   rd_data = scratch;
`ifdef DATA_MEM_CYCLE_CNT_EN
      OFF_CYCLE_CNT: rd_data = cycle_cnt;
`endif
      default:       rd_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM with post-reset zero-clear FSM and MMIO window.
// Define DATA_MEM_CYCLE_CNT_EN to enable the CYCLE_CNT register in the MMIO block.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_write,
  output logic [31:0]   mem_rdata,
  output logic          mem_ready,
  output logic [2:0]    err_status,
  input  logic [AW-1:0] debug_addr,
  output logic [31:0]   debug_data
);

  state_t        state, state_next;
  logic [AW-1:0] clr_ptr;
  logic [31:0]   ram [DEPTH_WORDS];

  logic          in_run;
  logic          is_mmio;
  logic          is_ram;
  logic          misaligned;
  logic          ram_we;
  logic          mmio_we;
  logic [AW-1:0] word_idx;
  logic [2:0]    status_set;
  logic [31:0]   mmio_rdata;

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_ptr == {AW{1'b1}}) state_next = RUN;
  end

  // mem_ready tracks the next state so it rises with the edge that leaves CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      mem_ready <= 1'b0;
    end else begin
      state     <= state_next;
      mem_ready <= (state_next == RUN);
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    in_run     = (state == RUN);
    is_mmio    = is_mmio_page(mem_addr[31:8]);
    is_ram     = (mem_addr[31:AW+2] == '0);
    misaligned = (mem_addr[1:0] != 2'b00);
    word_idx   = mem_addr[AW+1:2];
    ram_we     = in_run && is_ram && !misaligned && mem_write;
    mmio_we    = in_run && is_mmio && mem_write;

    status_set              = 3'b000;
    status_set[ST_MISALIGN] = in_run && is_ram && misaligned;
    status_set[ST_OOR]      = in_run && !is_ram && !is_mmio;
    status_set[ST_WR_CLEAR] = !in_run && mem_write;
  end

  // RAM contents are not reset; the CLEAR walk owns the write port until RUN
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ram[clr_ptr] <= 32'd0;
    end else if (ram_we) begin
      ram[word_idx] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = 32'd0;
    if (in_run) begin
      if (is_ram)       mem_rdata = ram[word_idx];
      else if (is_mmio) mem_rdata = mmio_rdata;
    end
    debug_data = in_run ? ram[debug_addr] : 32'd0;
  end

  dmem_mmio_regs u_mmio_regs (
    .clk        (clk),
    .rst        (rst),
    .run        (in_run),
    .status_set (status_set),
    .wr_en      (mmio_we),
    .offset     (mem_addr[7:0]),
    .wr_data    (mem_wdata),
    .store_inc  (ram_we),
    .rd_data    (mmio_rdata),
    .status     (err_status)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes model expectations, a monitor pops and compares.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
`ifdef DATA_MEM_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_write = 1'b0;
  logic [9:0]  debug_addr = 10'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  err_status;
  logic [31:0] debug_data;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .err_status (err_status),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  err;
    logic        ready;
    logic [31:0] dbg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: plain memory image, status bits, counters and remaining clear cycles
  logic [31:0] m_mem [DEPTH];
  logic [2:0]  m_status;
  logic [31:0] m_store;
  logic [31:0] m_scratch;
  logic [31:0] m_cycle;
  int          m_clear_left;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    m_status     = 3'b000;
    m_store      = 32'd0;
    m_scratch    = 32'd0;
    m_cycle      = 32'd0;
    m_clear_left = DEPTH;
  endtask

  function automatic logic [31:0] model_mmio_read(input logic [7:0] off);
    case (off)
      8'h00:   return {29'd0, m_status};
      8'h04:   return m_store;
      8'h08:   return m_scratch;
      8'h0C:   return CYC_EN ? m_cycle : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic pulse_reset();
    exp_t e;
    @(negedge clk);
    rst       = 1'b1;
    mem_write = 1'b0;
    model_reset();
    e.rdata = 32'd0;
    e.err   = 3'b000;
    e.ready = 1'b0;
    e.dbg   = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic we, input logic [9:0] dbg);
    exp_t       e;
    logic       run;
    logic       is_m;
    logic       is_r;
    logic       align;
    logic [7:0] off;
    logic [2:0] set_b;
    logic [2:0] clr_b;
    @(negedge clk);
    rst        = 1'b0;
    mem_addr   = addr;
    mem_wdata  = wdata;
    mem_write  = we;
    debug_addr = dbg;

    run   = (m_clear_left == 0);
    is_m  = (addr[31:8] == 24'hFFFFFF);
    is_r  = (addr < 32'(DEPTH * 4));
    align = (addr % 4 == 0);
    off   = addr[7:0];

    e.ready = run;
    e.err   = m_status;
    e.dbg   = run ? m_mem[dbg] : 32'd0;
    if (!run)      e.rdata = 32'd0;
    else if (is_r) e.rdata = m_mem[addr / 4];
    else if (is_m) e.rdata = model_mmio_read(off);
    else           e.rdata = 32'd0;
    exp_q.push_back(e);

    set_b = 3'b000;
    clr_b = 3'b000;
    if (!run && we) set_b[2] = 1'b1;
    if (run && is_r && !align) set_b[0] = 1'b1;
    if (run && !is_r && !is_m) set_b[1] = 1'b1;
    if (run && is_m && we && off == 8'h00) clr_b = wdata[2:0];
    m_status = (m_status & ~clr_b) | set_b;

    if (run && is_r && align && we) begin
      m_mem[addr / 4] = wdata;
      m_store         = m_store + 32'd1;
    end
    if (run && is_m && we && off == 8'h08) m_scratch = wdata;
    if (CYC_EN) begin
      if (run && is_m && we && off == 8'h0C) m_cycle = 32'd0;
      else if (run)                          m_cycle = m_cycle + 32'd1;
    end
    if (!run) m_clear_left--;
  endtask

  // Monitor: compares every queued expectation well after the input change and before the next edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("mem_rdata", mem_rdata, e.rdata);
        check_output("err_status", {29'd0, err_status}, {29'd0, e.err});
        check_output("mem_ready", {31'd0, mem_ready}, {31'd0, e.ready});
        check_output("debug_data", debug_data, e.dbg);
      end
    end
  end

  initial begin
    logic [31:0] r_addr;
    logic [7:0]  r_off;
    int          kind;
    model_reset();

    pulse_reset();
    for (int i = 0; i < DEPTH + 4; i++)
      apply_stimulus(32'd0, 32'd0, 1'b0, 10'(i % DEPTH));
    apply_stimulus(32'd0, 32'd0, 1'b0, 10'd0);
    apply_stimulus(32'd0, 32'd0, 1'b0, 10'd511);
    apply_stimulus(32'd0, 32'd0, 1'b0, 10'd1023);

    apply_stimulus(32'h0000_0010, 32'hDEADBEEF, 1'b1, 10'd4);
    apply_stimulus(32'h0000_0010, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'hFFFF_FF04, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'h0000_0012, 32'h1234_5678, 1'b1, 10'd4);
    apply_stimulus(32'h0000_0010, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'hFFFF_FF00, 32'h0000_0001, 1'b1, 10'd4);
    apply_stimulus(32'hFFFF_FF00, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'h0000_1000, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'h0000_1000, 32'hCAFE_F00D, 1'b1, 10'd4);
    apply_stimulus(32'hFFFF_FF04, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'hFFFF_FF00, 32'd0, 1'b0, 10'd4);
    apply_stimulus(32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 10'd1023);
    apply_stimulus(32'h0000_0FFC, 32'd0, 1'b0, 10'd1023);

    apply_stimulus(32'hFFFF_FF0C, 32'd0, 1'b0, 10'd0);
    repeat (4) apply_stimulus(32'd0, 32'd0, 1'b0, 10'd0);
    apply_stimulus(32'hFFFF_FF0C, 32'd0, 1'b0, 10'd0);
    apply_stimulus(32'hFFFF_FF0C, 32'd0, 1'b1, 10'd0);
    apply_stimulus(32'hFFFF_FF0C, 32'd0, 1'b0, 10'd0);
    apply_stimulus(32'hFFFF_FF0C, 32'd0, 1'b0, 10'd0);

    for (int i = 0; i < 800; i++) begin
      kind = $urandom_range(0, 9);
      r_off = 8'($urandom);
      if (kind <= 3)      r_addr = 32'($urandom_range(0, 63)) * 4;
      else if (kind == 4) r_addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 5) r_addr = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
      else if (kind <= 8) r_addr = {24'hFFFFFF, ($urandom_range(0, 4) == 4) ? r_off
                                                : 8'($urandom_range(0, 3) * 4)};
      else                r_addr = 32'h0000_0FFC;
      apply_stimulus(r_addr, $urandom, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 63)));
    end

    pulse_reset();
    for (int i = 0; i < 300; i++)
      apply_stimulus(32'($urandom_range(0, 63)) * 4, $urandom, 1'($urandom_range(0, 1)), 10'(i));
    apply_stimulus(32'h0000_0020, 32'h5555_AAAA, 1'b1, 10'd8);
    apply_stimulus(32'h0000_0020, 32'd0, 1'b0, 10'd8);
    pulse_reset();
    for (int i = 0; i < DEPTH + 4; i++)
      apply_stimulus(32'h0000_0020, 32'd0, 1'b0, 10'(i % DEPTH));
    apply_stimulus(32'h0000_0020, 32'd0, 1'b0, 10'd0);
    apply_stimulus(32'h0000_0024, 32'd0, 1'b0, 10'd511);
    apply_stimulus(32'hFFFF_FF04, 32'd0, 1'b0, 10'd1023);
    apply_stimulus(32'hFFFF_FF08, 32'd0, 1'b0, 10'd1023);

    repeat (3) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
